// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment display path.
// Segment order is {a,b,c,d,e,f,g}, bit 6 = a; encodings are active-high.
package seven_seg_pkg;

  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Indexed by the hex value; entry 15 (F) is listed first.
  localparam logic [15:0][6:0] SEG_FONT = {
    7'b1000111,  // F
    7'b1001111,  // E
    7'b0111101,  // d
    7'b1001110,  // C
    7'b0011111,  // b
    7'b1110111,  // A
    7'b1111011,  // 9
    7'b1111111,  // 8
    7'b1110000,  // 7
    7'b1011111,  // 6
    7'b1011011,  // 5
    7'b0110011,  // 4
    7'b1111001,  // 3
    7'b1101101,  // 2
    7'b0110000,  // 1
    7'b1111110   // 0
  };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-nibble to seven-segment decoder, active-high output.
module hex_to_seg7
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_FONT[i_hex];
  end

endmodule

// File: rtl/seven_seg_mux_driver.sv
// Time-multiplexed seven-segment driver with double-buffered display data,
// leading-zero blanking and frame-aligned updates.
module seven_seg_mux_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned REFRESH_DIV    = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);
  localparam logic [IdxW-1:0] IdxMax = IdxW'(NUM_DIGITS - 1);

  logic [CntW-1:0]         r_cnt;
  logic [IdxW-1:0]         r_idx;
  logic [4*NUM_DIGITS-1:0] r_pend_data;
  logic [NUM_DIGITS-1:0]   r_pend_dp;
  logic                    r_pend_valid;
  logic [4*NUM_DIGITS-1:0] r_act_data;
  logic [NUM_DIGITS-1:0]   r_act_dp;
  logic [6:0]              r_seg;
  logic                    r_dp;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_frame_done;

  logic                    w_cnt_wrap;
  logic                    w_boundary;
  logic [3:0]              w_nib;
  logic [NUM_DIGITS-1:0]   w_an_oh;
  logic                    w_dp_sel;
  logic                    w_blank_sel;
  logic [6:0]              w_seg_dec;

  assign w_cnt_wrap = (r_cnt == CntMax);
  assign w_boundary = en & w_cnt_wrap & (r_idx == IdxMax);

  // Walk from the leftmost digit down so the zero run covers digits above k too.
  always_comb begin
    logic lz_run;
    lz_run      = blank_lz;
    w_nib       = 4'h0;
    w_an_oh     = '0;
    w_dp_sel    = 1'b0;
    w_blank_sel = 1'b0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      lz_run = lz_run & (r_act_data[4*k +: 4] == 4'h0);
      if (r_idx == IdxW'(k)) begin
        w_nib       = r_act_data[4*k +: 4];
        w_an_oh[k]  = 1'b1;
        w_dp_sel    = r_act_dp[k];
        w_blank_sel = lz_run & (k != 0);
      end
    end
  end

  hex_to_seg7 u_hex_to_seg7 (
    .i_hex (w_nib),
    .o_seg (w_seg_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (en) begin
      if (w_cnt_wrap) begin
        r_cnt <= '0;
        r_idx <= (r_idx == IdxMax) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // A load landing on the boundary bypasses pending and takes effect next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_data  <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
      r_act_data   <= '0;
      r_act_dp     <= '0;
    end else if (load && w_boundary) begin
      r_act_data   <= data_in;
      r_act_dp     <= dp_in;
      r_pend_valid <= 1'b0;
    end else if (load) begin
      r_pend_data  <= data_in;
      r_pend_dp    <= dp_in;
      r_pend_valid <= 1'b1;
    end else if (w_boundary && r_pend_valid) begin
      r_act_data   <= r_pend_data;
      r_act_dp     <= r_pend_dp;
      r_pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg        <= SEG_BLANK;
      r_dp         <= 1'b0;
      r_an         <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_boundary;
      if (en) begin
        r_seg <= w_blank_sel ? SEG_BLANK : w_seg_dec;
        r_dp  <= w_dp_sel;
        r_an  <= w_an_oh;
      end else begin
        r_seg <= SEG_BLANK;
        r_dp  <= 1'b0;
        r_an  <= '0;
      end
    end
  end

  assign seg        = r_seg ^ {7{SEG_ACTIVE_LOW}};
  assign dp         = r_dp ^ SEG_ACTIVE_LOW;
  assign an         = r_an ^ {NUM_DIGITS{AN_ACTIVE_LOW}};
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_mux_driver.sv
// Scoreboard bench: a frame-position reference model predicts each cycle's outputs,
// a negedge monitor compares them against the driver.
module tb_seven_seg_mux_driver;

  localparam int ND = 4;
  localparam int RD = 4;
  localparam int FR = ND * RD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            en = 1'b0;
  logic            load = 1'b0;
  logic [4*ND-1:0] data_in = '0;
  logic [ND-1:0]   dp_in = '0;
  logic            blank_lz = 1'b0;
  logic [6:0]      seg;
  logic            dp;
  logic [ND-1:0]   an;
  logic            frame_done;

  seven_seg_mux_driver #(
    .NUM_DIGITS     (ND),
    .REFRESH_DIV    (RD),
    .SEG_ACTIVE_LOW (1'b1),
    .AN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0]    seg;
    logic          dp;
    logic [ND-1:0] an;
    logic          fd;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  // Active-high glyphs 0..F, written out independently of the design.
  logic [6:0] font [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Model: position within the frame plus the two display buffers.
  int m_pos;
  int m_act [ND];
  bit m_act_dp [ND];
  int m_pend [ND];
  bit m_pend_dp [ND];
  bit m_pend_v;

  function automatic exp_t blank_out();
    exp_t e;
    e.seg = 7'h7f;
    e.dp  = 1'b1;
    e.an  = '1;
    e.fd  = 1'b0;
    return e;
  endfunction

  task automatic model_reset();
    m_pos    = 0;
    m_pend_v = 0;
    for (int i = 0; i < ND; i++) begin
      m_act[i]     = 0;
      m_act_dp[i]  = 0;
      m_pend[i]    = 0;
      m_pend_dp[i] = 0;
    end
  endtask

  task automatic model_step(output exp_t e);
    int            dig;
    bit            bnd;
    bit            lz;
    logic [ND-1:0] oh;
    e = blank_out();
    if (!rst_n) begin
      model_reset();
    end else begin
      dig = m_pos / RD;
      bnd = en && (m_pos == FR - 1);
      if (en) begin
        lz = blank_lz && (dig != 0);
        for (int j = dig; j < ND; j++) if (m_act[j] != 0) lz = 0;
        oh      = '0;
        oh[dig] = 1'b1;
        e.an    = ~oh;
        e.seg   = lz ? 7'h7f : ~font[m_act[dig]];
        e.dp    = ~m_act_dp[dig];
      end
      e.fd = bnd;
      if (load && bnd) begin
        for (int i = 0; i < ND; i++) begin
          m_act[i]    = int'(data_in[4*i +: 4]);
          m_act_dp[i] = dp_in[i];
        end
        m_pend_v = 0;
      end else if (load) begin
        for (int i = 0; i < ND; i++) begin
          m_pend[i]    = int'(data_in[4*i +: 4]);
          m_pend_dp[i] = dp_in[i];
        end
        m_pend_v = 1;
      end else if (bnd && m_pend_v) begin
        for (int i = 0; i < ND; i++) begin
          m_act[i]    = m_pend[i];
          m_act_dp[i] = m_pend_dp[i];
        end
        m_pend_v = 0;
      end
      if (en) m_pos = (m_pos + 1) % FR;
    end
  endtask

  // Advance one clock: predict at the edge, then return just after it.
  task automatic cycle();
    exp_t e;
    @(posedge clk);
    model_step(e);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_blank(input string name);
    exp_t b;
    b = blank_out();
    n_vec++;
    if ({seg, dp, an, frame_done} !== b) begin
      n_bad++;
      $display("FAIL %s t=%0t: seg=%b dp=%b an=%b fd=%b, required seg=%b dp=%b an=%b fd=%b",
               name, $time, seg, dp, an, frame_done, b.seg, b.dp, b.an, b.fd);
    end
  endtask

  task automatic async_reset();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_blank("reset_async");
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if ({seg, dp, an, frame_done} !== e) begin
          n_bad++;
          $display("FAIL scoreboard t=%0t: seg=%b dp=%b an=%b fd=%b, required seg=%b dp=%b an=%b fd=%b",
                   $time, seg, dp, an, frame_done, e.seg, e.dp, e.an, e.fd);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_blank("reset_hold");
    repeat (3) cycle();
    rst_n = 1'b1;
    en    = 1'b1;
    repeat (40) cycle();

    // Mid-frame load: must not appear until the next frame.
    data_in = 16'h12AF;
    dp_in   = 4'b0010;
    load    = 1'b1;
    cycle();
    load = 1'b0;
    repeat (40) cycle();

    // Load exactly on the frame boundary.
    for (int k = 0; k < FR && m_pos != FR - 1; k++) cycle();
    data_in = 16'h5555;
    dp_in   = 4'b0000;
    load    = 1'b1;
    cycle();
    load = 1'b0;
    repeat (36) cycle();

    // Leading-zero blanking.
    blank_lz = 1'b1;
    data_in  = 16'h0030;
    load     = 1'b1;
    cycle();
    load = 1'b0;
    repeat (40) cycle();

    // Disable mid-digit, then resume.
    for (int k = 0; k < RD && (m_pos % RD) != 1; k++) cycle();
    en = 1'b0;
    repeat (10) cycle();
    en = 1'b1;
    repeat (20) cycle();

    // Reset after a load: the loaded value must be lost.
    data_in = 16'h9876;
    dp_in   = 4'b1010;
    load    = 1'b1;
    cycle();
    load = 1'b0;
    repeat (2) cycle();
    async_reset();
    blank_lz = 1'b0;
    repeat (40) cycle();

    for (int n = 0; n < 1500; n++) begin
      en      = ($urandom_range(0, 9) != 0);
      load    = ($urandom_range(0, 7) == 0);
      data_in = 16'($urandom) >> $urandom_range(0, 15);
      dp_in   = 4'($urandom);
      if ($urandom_range(0, 49) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 299) == 0) begin
        load = 1'b0;
        async_reset();
      end else begin
        cycle();
      end
    end
    load = 1'b0;

    @(negedge clk);
    #1;
    n_vec++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_seg_mux_driver.md
SEVEN_SEG_MUX_DRIVER -- requirements
Module: seven_seg_mux_driver

Interface
REQ-001 SHALL provide parameter NUM_DIGITS, default 4: number of multiplexed digits, legal range 1..8.
REQ-002 SHALL provide parameter REFRESH_DIV, default 1000: clk cycles each digit is driven, legal range >=2.
REQ-003 SHALL provide parameter SEG_ACTIVE_LOW, default 1: 1 means a lit segment/dp drives 0.
REQ-004 SHALL provide parameter AN_ACTIVE_LOW, default 1: 1 means a selected anode drives 0.
REQ-005 SHALL have clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL have en  input  1  scan enable.
REQ-008 SHALL have load  input  1  one-cycle strobe capturing data_in/dp_in.
REQ-009 SHALL have data_in  input  4*NUM_DIGITS  hex nibbles; nibble 0 = rightmost digit.
REQ-010 SHALL have dp_in  input  NUM_DIGITS  decimal-point request per digit.
REQ-011 SHALL have blank_lz  input  1  leading-zero blanking enable.
REQ-012 SHALL have seg  output  7  segments {a,b,c,d,e,f,g}, a = bit 6.
REQ-013 SHALL have dp  output  1  decimal point of the selected digit.
REQ-014 SHALL have an  output  NUM_DIGITS  one-hot anode select.
REQ-015 SHALL have frame_done  output  1  one-cycle pulse at each frame end.

Function
REQ-016 SHALL hold a pending buffer, a pending_valid flag, an active buffer, a refresh counter (0..REFRESH_DIV-1) and a digit index (0..NUM_DIGITS-1).
REQ-017 load SHALL capture data_in/dp_in into pending and set pending_valid, independent of en.
REQ-018 Frame boundary = cycle where en=1, counter=REFRESH_DIV-1 and index=NUM_DIGITS-1.
REQ-019 At a frame boundary with pending_valid=1, pending SHALL copy to active and pending_valid SHALL clear; the displayed value never changes mid-frame.
REQ-020 load coincident with a frame boundary SHALL write data_in/dp_in directly to active and leave pending_valid=0.
REQ-021 With en=1, counter SHALL increment each cycle and wrap to 0 after REFRESH_DIV-1; on wrap, index SHALL increment, wrapping NUM_DIGITS-1 -> 0.
REQ-022 frame_done SHALL be 1 for exactly the cycle after the frame boundary.
REQ-023 With en=0, counter and index SHALL hold; an SHALL be all inactive and seg/dp all unlit from the next cycle.
REQ-024 seg, dp and an SHALL be registered, reflecting the current index with one cycle of latency.
REQ-025 Decode SHALL cover all 16 values 0-F in standard form (0=1111110, 1=0110000, 8=1111111, A=1110111, F=1000111, active-high).
REQ-026 With blank_lz=1, digit k SHALL be blanked (seg unlit) when nibbles NUM_DIGITS-1..k are all zero; digit 0 is never blanked; dp is never suppressed by blanking.
REQ-027 Polarity parameters SHALL invert outputs only, never internal state.

Reset
REQ-028 rst_n=0 SHALL immediately clear counter, index, pending, pending_valid and active to 0.
REQ-029 During reset, seg/dp SHALL be unlit and an all inactive (polarity applied), and frame_done SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard pending data; scanning restarts at index 0, counter 0, after release.

Structure
REQ-031 Package seven_seg_pkg SHALL hold the 16 segment encodings, SEG_BLANK and the segment-bit index constants.
REQ-032 Decoding SHALL live in combinational sub-module hex_to_seg7 (4-bit in, 7-bit active-high out), instantiated once on the muxed nibble.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, both polarities active-low)
REQ-033 Reset release, en=1, no load -> an cycles 1110,1101,1011,0111, each for 4 cycles; seg=0000001 (digit "0") on every digit; frame_done pulses every 16 cycles.
REQ-034 load data_in=16'h12AF mid-frame -> old value shown until frame end; next frame digits 0..3 show F,A,2,1 (seg 0111000,0001000,0010010,1001111).
REQ-035 blank_lz=1, data_in=16'h0030 -> digits 3,2 seg=1111111; digit 1 = "3"; digit 0 = "0" not blanked.
REQ-036 load pulsed on the frame-boundary cycle with 16'h5555 -> next frame shows 5555, pending_valid=0.
REQ-037 en dropped for 10 cycles mid-digit -> an=1111, seg=1111111; on re-enable, scan resumes at the same index with the held counter value.
REQ-038 rst_n pulsed low mid-frame after a load -> outputs blank immediately; after release, display shows 0000 and the loaded data is lost.
